// File: rtl/shake_pkg.sv
// Shared types and constants for the SHAKE sponge absorb front-end.
package shake_pkg;

    localparam int RATE128 = 21;
    localparam int RATE256 = 17;

    localparam logic [7:0] SHAKE_DOM = 8'h1F;
    localparam logic [7:0] SHA3_DOM  = 8'h06;
    localparam logic [7:0] PAD_END   = 8'h80;

    typedef logic [63:0]             lane_t;
    typedef logic [4:0][4:0][63:0]   state_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ABSORB,
        S_PAD,
        S_SEND,
        S_WAIT,
        S_DONE
    } absorb_state_e;

    // Lane i lives at state[i%5][i/5]; entry 0 is the rightmost element.
    localparam logic [24:0][2:0] LANE_X = {5{3'd4, 3'd3, 3'd2, 3'd1, 3'd0}};
    localparam logic [24:0][2:0] LANE_Y = {{5{3'd4}}, {5{3'd3}}, {5{3'd2}}, {5{3'd1}}, {5{3'd0}}};

endpackage

// File: rtl/shake_lane_mask.sv
// Byte-valid mask for a partial message word and domain-byte placement for padding.
module shake_lane_mask
    import shake_pkg::*;
(
    input  logic [3:0] nbytes,
    input  logic [2:0] pad_byte,
    input  logic [7:0] dom,
    output lane_t      mask,
    output lane_t      pad_word
);

    // Keep the low nbytes bytes; 8 or more means the whole lane.
    always_comb begin
        mask = '0;
        for (int k = 0; k < 8; k++) begin
            if (4'(k) < nbytes) mask[8*k +: 8] = 8'hFF;
        end
    end

    assign pad_word = lane_t'(dom) << {pad_byte, 3'b000};

endmodule

// File: rtl/shake_absorb.sv
// SHAKE sponge absorb front-end: XORs message words into the rate lanes,
// applies pad10*1 with the domain byte, and trades blocks with the
// Keccak-f[1600] datapath over a valid/ready handshake.
// Optional: SHAKE_ABSORB_DOMAIN_SEL_EN adds xof_sel (1 = 0x1F SHAKE, 0 = 0x06 SHA3),
// sampled on start; otherwise the domain byte is fixed at 0x1F.
module shake_absorb
    import shake_pkg::*;
#(
    parameter int RATE_LANES = RATE128,
    parameter int LANE_W     = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
`ifdef SHAKE_ABSORB_DOMAIN_SEL_EN
    input  logic        xof_sel,
`endif
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    input  logic [3:0]  in_bytes,
    input  logic        in_last,
    output logic        blk_valid,
    input  logic        blk_ready,
    output state_t      state_out,
    input  logic        perm_valid,
    input  state_t      state_in,
    output logic        busy,
    output logic        absorb_done
);

    localparam logic [4:0] LAST_LANE = 5'(RATE_LANES - 1);
    localparam lane_t      END_WORD  = lane_t'(PAD_END) << (LANE_W - 8);

    absorb_state_e fsm, fsm_nxt;
    state_t        st, xor_vec;
    logic [4:0]    lane_cnt, pad_lane;
    logic [2:0]    pad_byte;
    logic          pad_pend, final_blk;
    logic [7:0]    dom;
    logic          clr, acc, pad, load;
    logic          at_last;
    lane_t         in_mask, pad_word;

    assign at_last   = (lane_cnt == LAST_LANE);
    assign state_out = st;

`ifdef SHAKE_ABSORB_DOMAIN_SEL_EN
    // Domain byte is chosen once per message, when start is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)     dom <= SHAKE_DOM;
        else if (clr) dom <= xof_sel ? SHAKE_DOM : SHA3_DOM;
    end
`else
    assign dom = SHAKE_DOM;
`endif

    shake_lane_mask u_mask (
        .nbytes   (in_bytes),
        .pad_byte (pad_byte),
        .dom      (dom),
        .mask     (in_mask),
        .pad_word (pad_word)
    );

    // Per-lane XOR contribution: message word on absorb, domain and end bits on pad.
    always_comb begin
        lane_t v;
        xor_vec = '0;
        v       = '0;
        for (int i = 0; i < 25; i++) begin
            v = '0;
            if (acc && lane_cnt == 5'(i))     v = v ^ (in_data & in_mask);
            if (pad && pad_lane == 5'(i))     v = v ^ pad_word;
            if (pad && i == RATE_LANES - 1)   v = v ^ END_WORD;
            xor_vec[LANE_X[i]][LANE_Y[i]] = v;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) fsm <= S_IDLE;
        else      fsm <= fsm_nxt;
    end

    // Next-state, datapath strobes and status outputs.
    always_comb begin
        fsm_nxt     = fsm;
        clr         = 1'b0;
        acc         = 1'b0;
        pad         = 1'b0;
        load        = 1'b0;
        in_ready    = 1'b0;
        blk_valid   = 1'b0;
        busy        = 1'b1;
        absorb_done = 1'b0;
        case (fsm)
            S_IDLE, S_DONE: begin
                busy        = 1'b0;
                absorb_done = (fsm == S_DONE);
                if (start) begin
                    clr     = 1'b1;
                    fsm_nxt = S_ABSORB;
                end
            end
            S_ABSORB: begin
                in_ready = 1'b1;
                // start beats a simultaneous word and restarts the message
                if (start) begin
                    clr = 1'b1;
                end else if (in_valid) begin
                    acc = 1'b1;
                    if (!in_last)                          fsm_nxt = at_last ? S_SEND : S_ABSORB;
                    else if (in_bytes < 4'd8 || !at_last)  fsm_nxt = S_PAD;
                    else                                   fsm_nxt = S_SEND;
                end
            end
            S_PAD: begin
                pad     = 1'b1;
                fsm_nxt = S_SEND;
            end
            S_SEND: begin
                blk_valid = 1'b1;
                if (blk_ready) fsm_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (perm_valid) begin
                    load = 1'b1;
                    if (pad_pend)       fsm_nxt = S_PAD;
                    else if (final_blk) fsm_nxt = S_DONE;
                    else                fsm_nxt = S_ABSORB;
                end
            end
            default: fsm_nxt = S_IDLE;
        endcase
    end

    // State array, lane counter and padding bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st        <= '0;
            lane_cnt  <= '0;
            pad_lane  <= '0;
            pad_byte  <= '0;
            pad_pend  <= 1'b0;
            final_blk <= 1'b0;
        end else if (clr) begin
            st        <= '0;
            lane_cnt  <= '0;
            pad_lane  <= '0;
            pad_byte  <= '0;
            pad_pend  <= 1'b0;
            final_blk <= 1'b0;
        end else if (load) begin
            st       <= state_in;
            pad_pend <= 1'b0;
        end else begin
            if (acc || pad) st <= st ^ xor_vec;
            if (pad)        final_blk <= 1'b1;
            if (acc) begin
                if (!in_last) begin
                    lane_cnt <= at_last ? 5'd0 : lane_cnt + 5'd1;
                end else if (in_bytes < 4'd8) begin
                    pad_lane <= lane_cnt;
                    pad_byte <= in_bytes[2:0];
                end else if (!at_last) begin
                    pad_lane <= lane_cnt + 5'd1;
                    pad_byte <= 3'd0;
                end else begin
                    // message fills the block exactly: padding goes in a block of its own
                    pad_pend <= 1'b1;
                    pad_lane <= 5'd0;
                    pad_byte <= 3'd0;
                end
            end
        end
    end

endmodule

// File: tb/tb_shake_absorb.sv
// Directed bench for shake_absorb: single-word table, multi-block, stall, abort and reset sequences.
module tb_shake_absorb;
    import shake_pkg::*;

    localparam lane_t END_W = 64'h8000_0000_0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a, start_b, in_valid, in_last, blk_ready, perm_valid;
    logic [63:0] in_data;
    logic [3:0]  in_bytes;
    state_t      state_in, st_a, st_b, exp;
    logic        rdy_a, bv_a, busy_a, done_a;
    logic        rdy_b, bv_b, busy_b, done_b;
`ifdef SHAKE_ABSORB_DOMAIN_SEL_EN
    logic        xof_sel = 1'b1;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [63:0] data;
        logic [3:0]  nb;
        lane_t       l0;
        lane_t       l1;
    } vec_t;
    vec_t vt [6];

    always #5 clk = ~clk;

    shake_absorb #(.RATE_LANES(RATE128)) dut_a (
        .clk(clk), .rst(rst), .start(start_a),
`ifdef SHAKE_ABSORB_DOMAIN_SEL_EN
        .xof_sel(xof_sel),
`endif
        .in_valid(in_valid), .in_ready(rdy_a), .in_data(in_data), .in_bytes(in_bytes),
        .in_last(in_last), .blk_valid(bv_a), .blk_ready(blk_ready), .state_out(st_a),
        .perm_valid(perm_valid), .state_in(state_in), .busy(busy_a), .absorb_done(done_a)
    );

    shake_absorb #(.RATE_LANES(RATE256)) dut_b (
        .clk(clk), .rst(rst), .start(start_b),
`ifdef SHAKE_ABSORB_DOMAIN_SEL_EN
        .xof_sel(xof_sel),
`endif
        .in_valid(in_valid), .in_ready(rdy_b), .in_data(in_data), .in_bytes(in_bytes),
        .in_last(in_last), .blk_valid(bv_b), .blk_ready(blk_ready), .state_out(st_b),
        .perm_valid(perm_valid), .state_in(state_in), .busy(busy_b), .absorb_done(done_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, want);
        end
    endtask

    task automatic chk_st(input string nm, input state_t got, input state_t want);
        int bad;
        bad = -1;
        n_chk++;
        for (int i = 24; i >= 0; i--)
            if (got[i%5][i/5] !== want[i%5][i/5]) bad = i;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL %s: lane %0d got %h expected %h", nm, bad,
                     got[bad%5][bad/5], want[bad%5][bad/5]);
        end
    endtask

    function automatic state_t xl(input state_t s, input int i, input lane_t v);
        s[i%5][i/5] = s[i%5][i/5] ^ v;
        return s;
    endfunction

    function automatic lane_t pat(input int seed, input int i);
        return {16'(seed), 16'(i), 32'hC0DE_0000 | 32'(i * 7)};
    endfunction

    function automatic state_t mk(input int seed);
        state_t s;
        for (int i = 0; i < 25; i++) s[i%5][i/5] = pat(seed, i);
        return s;
    endfunction

    task automatic send(input logic [63:0] d, input logic [3:0] nb, input logic last, input bit on_b);
        int n;
        n = 0;
        in_data  = d;
        in_bytes = nb;
        in_last  = last;
        in_valid = 1'b1;
        while (!(on_b ? rdy_b : rdy_a) && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) begin
            n_chk++;
            n_fail++;
            $display("FAIL send: in_ready got 0 expected 1 within 40 cycles");
        end else begin
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic start_pulse();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
    endtask

    task automatic blk_hs();
        blk_ready = 1'b1;
        tick();
        blk_ready = 1'b0;
    endtask

    task automatic perm(input state_t s);
        state_in   = s;
        perm_valid = 1'b1;
        tick();
        perm_valid = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got still running expected finished");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        start_a = 1'b0; start_b = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        blk_ready = 1'b0; perm_valid = 1'b0; in_data = '0; in_bytes = '0; state_in = '0;

        vt[0] = '{64'h0,                   4'd0, 64'h0000_0000_0000_001F, 64'h0};
        vt[1] = '{64'h0000_0000_0063_6261, 4'd3, 64'h0000_0000_1F63_6261, 64'h0};
        vt[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 4'd5, 64'h0000_1FFF_FFFF_FFFF, 64'h0};
        vt[3] = '{64'h0123_4567_89AB_CDEF, 4'd8, 64'h0123_4567_89AB_CDEF, 64'h1F};
        vt[4] = '{64'hAAAA_AAAA_AAAA_AAAA, 4'd7, 64'h1FAA_AAAA_AAAA_AAAA, 64'h0};
        vt[5] = '{64'h1122_3344_5566_7788, 4'd1, 64'h0000_0000_0000_1F88, 64'h0};

        tick(); tick();
        chk("reset in_ready", 64'(rdy_a), 64'd0);
        chk("reset blk_valid", 64'(bv_a), 64'd0);
        chk("reset busy", 64'(busy_a), 64'd0);
        chk("reset absorb_done", 64'(done_a), 64'd0);
        chk_st("reset state", st_a, '0);
        rst = 1'b1;
        tick();

        // single-word messages: pad timing, block contents, permutation reload
        for (int v = 0; v < 6; v++) begin
            start_pulse();
            chk("busy after start", 64'(busy_a), 64'd1);
            chk("done cleared by start", 64'(done_a), 64'd0);
            send(vt[v].data, vt[v].nb, 1'b1, 1'b0);
            chk("pad cycle blk_valid", 64'(bv_a), 64'd0);
            tick();
            chk("blk_valid two cycles after word", 64'(bv_a), 64'd1);
            exp = '0;
            exp = xl(exp, 0, vt[v].l0);
            exp = xl(exp, 1, vt[v].l1);
            exp = xl(exp, 20, END_W);
            chk_st("single word block", st_a, exp);
            blk_hs();
            perm(mk(v));
            chk("absorb_done after perm", 64'(done_a), 64'd1);
            chk_st("state reloaded", st_a, mk(v));
        end

        // stall in SEND: block held, start and perm_valid ignored
        start_pulse();
        send(64'h0123_4567_89AB_CDEF, 4'd8, 1'b1, 1'b0);
        tick();
        exp = xl(xl(xl('0, 0, 64'h0123_4567_89AB_CDEF), 1, 64'h1F), 20, END_W);
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                start_a = 1'b1;
                perm_valid = 1'b1;
                state_in = mk(99);
            end
            tick();
            start_a = 1'b0;
            perm_valid = 1'b0;
            chk("stall blk_valid", 64'(bv_a), 64'd1);
            chk("stall in_ready", 64'(rdy_a), 64'd0);
            chk_st("stall state", st_a, exp);
        end
        blk_hs();
        chk("wait blk_valid", 64'(bv_a), 64'd0);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("start ignored in wait", 64'(busy_a), 64'd1);
        perm(mk(7));
        chk("stall seq done", 64'(done_a), 64'd1);
        state_in = mk(8);
        perm_valid = 1'b1;
        tick();
        perm_valid = 1'b0;
        chk_st("perm ignored in done", st_a, mk(7));

        // exactly one full block: padding goes in a second block
        start_pulse();
        for (int i = 0; i < 21; i++) send(pat(50, i), 4'd8, 1'(i == 20), 1'b0);
        chk("full block straight to send", 64'(bv_a), 64'd1);
        exp = '0;
        for (int i = 0; i < 21; i++) exp = xl(exp, i, pat(50, i));
        chk_st("unpadded first block", st_a, exp);
        blk_hs();
        perm(mk(60));
        chk("pad block pending", 64'(bv_a), 64'd0);
        chk("not done after first perm", 64'(done_a), 64'd0);
        tick();
        chk("pad-only block valid", 64'(bv_a), 64'd1);
        chk_st("pad-only block", st_a, xl(xl(mk(60), 0, 64'h1F), 20, END_W));
        blk_hs();
        perm(mk(61));
        chk("done after second perm", 64'(done_a), 64'd1);
        chk_st("final state", st_a, mk(61));

        // 21 words then a short last word in the next block
        start_pulse();
        for (int i = 0; i < 21; i++) send(pat(70, i), 4'd8, 1'b0, 1'b0);
        chk("block boundary send", 64'(bv_a), 64'd1);
        blk_hs();
        perm(mk(70));
        chk("back to absorb", 64'(rdy_a), 64'd1);
        send(64'h0000_0000_0000_BEEF, 4'd2, 1'b1, 1'b0);
        tick();
        chk_st("second block padded", st_a, xl(xl(mk(70), 0, 64'h1FBEEF), 20, END_W));
        blk_hs();
        perm(mk(71));
        chk("two block done", 64'(done_a), 64'd1);

        // abort in ABSORB; start beats a simultaneous word
        start_pulse();
        send(pat(80, 0), 4'd8, 1'b0, 1'b0);
        send(pat(80, 1), 4'd8, 1'b0, 1'b0);
        start_a  = 1'b1;
        in_valid = 1'b1;
        in_data  = {8{SHA3_DOM}};
        in_bytes = 4'd8;
        in_last  = 1'b1;
        tick();
        start_a = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        chk("restart in_ready", 64'(rdy_a), 64'd1);
        chk_st("restart cleared state", st_a, '0);
        send(64'h0, 4'd0, 1'b1, 1'b0);
        tick();
        chk_st("restart block", st_a, xl(xl('0, 0, 64'h1F), 20, END_W));

        // reset while waiting for the permutation
        blk_hs();
        chk("in wait before reset", 64'(busy_a), 64'd1);
        rst = 1'b0;
        #1;
        chk("async reset busy", 64'(busy_a), 64'd0);
        chk("async reset blk_valid", 64'(bv_a), 64'd0);
        chk("async reset in_ready", 64'(rdy_a), 64'd0);
        chk("async reset done", 64'(done_a), 64'd0);
        chk_st("async reset state", st_a, '0);
        #2;
        rst = 1'b1;
        perm(mk(90));
        chk("perm after reset ignored busy", 64'(busy_a), 64'd0);
        chk_st("perm after reset ignored state", st_a, '0);

        // SHAKE256 rate: pad domain and end bit land in the same byte
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int i = 0; i < 16; i++) send(pat(100, i), 4'd8, 1'b0, 1'b1);
        send(64'hFFFF_FFFF_FFFF_FFFF, 4'd7, 1'b1, 1'b1);
        chk("rate17 pad cycle", 64'(bv_b), 64'd0);
        tick();
        chk("rate17 blk_valid", 64'(bv_b), 64'd1);
        chk("rate17 lane16", st_b[1][3], 64'h9FFF_FFFF_FFFF_FFFF);
        exp = '0;
        for (int i = 0; i < 16; i++) exp = xl(exp, i, pat(100, i));
        exp = xl(exp, 16, 64'h9FFF_FFFF_FFFF_FFFF);
        chk_st("rate17 block", st_b, exp);
        chk("rate128 instance idle", 64'(busy_a), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
